// File: rtl/ctrl_sequence_recorder.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_sequence_recorder
// Brief    : Run-length records a 3-bit control stream into sequence memory.
// Revision : 1.0
// ============================================================================
module ctrl_sequence_recorder #(
    parameter int DUR_W  = 13,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rec_en,
    input  logic [2:0]        ctrl_in,
    input  logic [3:0]        dig1,
    input  logic [3:0]        dig2,
    input  logic [3:0]        dig3,
    input  logic [3:0]        dig4,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    output logic              mem_we,
    output logic [ADDR_W-1:0] entry_count,
    output logic              busy,
    output logic              full,
    output logic              done
);

    localparam logic [2:0] C_S_IDLE     = 3'd0;
    localparam logic [2:0] C_S_HEADER   = 3'd1;
    localparam logic [2:0] C_S_RUN      = 3'd2;
    localparam logic [2:0] C_S_TERM     = 3'd3;
    localparam logic [2:0] C_S_DONE     = 3'd4;
    localparam logic [2:0] C_S_WAIT_LOW = 3'd5;

    localparam logic [ADDR_W-1:0] C_LAST_ADDR   = '1;
    localparam logic [ADDR_W-1:0] C_FIRST_ENTRY = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [DUR_W-1:0]  C_DUR_MAX     = '1;
    localparam logic [DUR_W-1:0]  C_DUR_ONE     = {{(DUR_W-1){1'b0}}, 1'b1};

    logic [2:0]        state_q,       state_d;
    logic [ADDR_W-1:0] wr_ptr_q,      wr_ptr_d;
    logic [2:0]        cur_ctrl_q,    cur_ctrl_d;
    logic [DUR_W-1:0]  dur_q,         dur_d;
    logic [ADDR_W-1:0] mem_addr_q,    mem_addr_d;
    logic [15:0]       mem_din_q,     mem_din_d;
    logic              mem_we_q,      mem_we_d;
    logic [ADDR_W-1:0] entry_count_q, entry_count_d;
    logic              busy_q,        busy_d;
    logic              full_q,        full_d;
    logic              done_q,        done_d;

    // Every output is registered, so busy/full/done line up with the write
    // that the same edge presents on the memory port.
    always_comb begin
        state_d       = state_q;
        wr_ptr_d      = wr_ptr_q;
        cur_ctrl_d    = cur_ctrl_q;
        dur_d         = dur_q;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        mem_we_d      = 1'b0;
        entry_count_d = entry_count_q;
        busy_d        = 1'b0;
        full_d        = full_q;
        done_d        = 1'b0;

        case (state_q)
            C_S_IDLE: begin
                if (rec_en) begin
                    state_d = C_S_HEADER;
                end
            end
            C_S_HEADER: begin
                busy_d        = 1'b1;
                mem_we_d      = 1'b1;
                mem_addr_d    = '0;
                mem_din_d     = {dig1, dig2, dig3, dig4};
                entry_count_d = '0;
                full_d        = 1'b0;
                wr_ptr_d      = C_FIRST_ENTRY;
                cur_ctrl_d    = ctrl_in;
                dur_d         = C_DUR_ONE;
                state_d       = C_S_RUN;
            end
            C_S_RUN: begin
                busy_d = 1'b1;
                if (!rec_en || (ctrl_in != cur_ctrl_q)) begin
                    mem_we_d      = 1'b1;
                    mem_addr_d    = wr_ptr_q;
                    mem_din_d     = {dur_q, cur_ctrl_q};
                    wr_ptr_d      = wr_ptr_q + 1'b1;
                    entry_count_d = entry_count_q + 1'b1;
                    cur_ctrl_d    = ctrl_in;
                    dur_d         = C_DUR_ONE;
                    // Filling the last slot closes the sequence with no terminator.
                    if (wr_ptr_q == C_LAST_ADDR) begin
                        full_d  = 1'b1;
                        state_d = C_S_DONE;
                    end else if (!rec_en) begin
                        state_d = C_S_TERM;
                    end
                end else if (dur_q != C_DUR_MAX) begin
                    dur_d = dur_q + 1'b1;
                end
            end
            C_S_TERM: begin
                busy_d     = 1'b1;
                mem_we_d   = 1'b1;
                mem_addr_d = wr_ptr_q;
                mem_din_d  = '0;
                state_d    = C_S_DONE;
            end
            C_S_DONE: begin
                done_d  = 1'b1;
                state_d = rec_en ? C_S_WAIT_LOW : C_S_IDLE;
            end
            C_S_WAIT_LOW: begin
                if (!rec_en) begin
                    state_d = C_S_IDLE;
                end
            end
            default: begin
                state_d = C_S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= C_S_IDLE;
            wr_ptr_q      <= '0;
            cur_ctrl_q    <= '0;
            dur_q         <= '0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            mem_we_q      <= 1'b0;
            entry_count_q <= '0;
            busy_q        <= 1'b0;
            full_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_ptr_q      <= wr_ptr_d;
            cur_ctrl_q    <= cur_ctrl_d;
            dur_q         <= dur_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            mem_we_q      <= mem_we_d;
            entry_count_q <= entry_count_d;
            busy_q        <= busy_d;
            full_q        <= full_d;
            done_q        <= done_d;
        end
    end

    assign mem_addr    = mem_addr_q;
    assign mem_din     = mem_din_q;
    assign mem_we      = mem_we_q;
    assign entry_count = entry_count_q;
    assign busy        = busy_q;
    assign full        = full_q;
    assign done        = done_q;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_sequence_recorder.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_sequence_recorder
// Brief    : Directed self-checking bench for ctrl_sequence_recorder.
// Revision : 1.0
// ============================================================================
module tb_ctrl_sequence_recorder;

    logic        clk;
    logic        rst;
    logic        rec_en;
    logic [2:0]  ctrl_in;
    logic [3:0]  dig1, dig2, dig3, dig4;
    logic [4:0]  mem_addr;
    logic [15:0] mem_din;
    logic        mem_we;
    logic [4:0]  entry_count;
    logic        busy;
    logic        full;
    logic        done;

    int n_cmp = 0;
    int n_err = 0;
    int done_cnt = 0;
    logic [4:0]  wa[$];
    logic [15:0] wd[$];

    ctrl_sequence_recorder #(.DUR_W(13), .ADDR_W(5)) u_dut (
        .clk         (clk),
        .rst         (rst),
        .rec_en      (rec_en),
        .ctrl_in     (ctrl_in),
        .dig1        (dig1),
        .dig2        (dig2),
        .dig3        (dig3),
        .dig4        (dig4),
        .mem_addr    (mem_addr),
        .mem_din     (mem_din),
        .mem_we      (mem_we),
        .entry_count (entry_count),
        .busy        (busy),
        .full        (full),
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write/done log sampled mid-cycle, away from the active edge.
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_din);
        end
        if (done) done_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    function automatic logic [15:0] data_at(input int i);
        return (i < wd.size()) ? wd[i] : 16'hxxxx;
    endfunction

    function automatic logic [4:0] addr_at(input int i);
        return (i < wa.size()) ? wa[i] : 5'bxxxxx;
    endfunction

    task automatic clear_log();
        wa.delete();
        wd.delete();
        done_cnt = 0;
    endtask

    task automatic wait_done(input int budget);
        int start_cnt;
        int n;
        start_cnt = done_cnt;
        n = 0;
        while (done_cnt == start_cnt && n < budget) begin
            step(1);
            n++;
        end
        check_val("done_seen", 32'(done_cnt != start_cnt), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int bad;
        int n_before;

        // Reset held with a pending request
        rst = 1'b0; rec_en = 1'b1; ctrl_in = 3'b001;
        dig1 = 4'd1; dig2 = 4'd2; dig3 = 4'd3; dig4 = 4'd4;
        step(3);
        check_val("rst_outputs", {mem_addr, mem_din, mem_we, entry_count, busy, full, done}, 32'd0);
        check_val("rst_no_write", wa.size(), 0);

        // Basic recording: 001 x5, 010 x3
        rst = 1'b1;
        step(2);
        check_val("hdr_we", mem_we, 1);
        check_val("hdr_addr", mem_addr, 0);
        check_val("hdr_din", mem_din, 32'h1234);
        check_val("hdr_busy", busy, 1);
        step(4);
        ctrl_in = 3'b010;
        step(3);
        rec_en = 1'b0;
        wait_done(10);
        step(2);
        check_val("basic_nwr", wa.size(), 4);
        check_val("basic_d0", data_at(0), 32'h1234);
        check_val("basic_d1", data_at(1), 32'h0029);
        check_val("basic_d2", data_at(2), 32'h001A);
        check_val("basic_d3", data_at(3), 32'h0000);
        check_val("basic_a3", addr_at(3), 3);
        check_val("basic_cnt", entry_count, 2);
        check_val("basic_done1", done_cnt, 1);
        check_val("basic_idle", {busy, full}, 0);

        // Fast toggling until full
        clear_log();
        ctrl_in = 3'b001; rec_en = 1'b1;
        step(2);
        for (int i = 0; i < 40; i++) begin
            ctrl_in = (i % 2 == 0) ? 3'b100 : 3'b001;
            step(1);
        end
        check_val("fast_nwr", wa.size(), 32);
        bad = 0;
        for (int k = 1; k < 32; k++) begin
            if (addr_at(k) !== 5'(k)) bad++;
            if (data_at(k) !== ((k % 2 == 1) ? 16'h0009 : 16'h000C)) bad++;
        end
        check_val("fast_entries", bad, 0);
        check_val("fast_full", full, 1);
        check_val("fast_cnt", entry_count, 31);
        check_val("fast_done1", done_cnt, 1);

        // Held request never re-records
        n_before = wa.size();
        step(20);
        check_val("held_no_write", wa.size(), n_before);
        check_val("held_busy", busy, 0);
        rec_en = 1'b0;
        step(2);
        rec_en = 1'b1;
        step(2);
        check_val("rearm_hdr", {mem_we, mem_addr, mem_din}, {1'b1, 5'd0, 16'h1234});
        check_val("rearm_full_clr", full, 0);
        rec_en = 1'b0;
        wait_done(10);
        step(2);

        // Duration saturation
        clear_log();
        ctrl_in = 3'b011; rec_en = 1'b1;
        step(9001);
        rec_en = 1'b0;
        wait_done(10);
        step(2);
        check_val("sat_nwr", wa.size(), 3);
        check_val("sat_d1", data_at(1), 32'hFFFB);
        check_val("sat_d2", data_at(2), 32'h0000);
        check_val("sat_a2", addr_at(2), 2);

        // Stop coincident with a value change
        clear_log();
        ctrl_in = 3'b001; rec_en = 1'b1;
        step(4);
        rec_en = 1'b0; ctrl_in = 3'b010;
        wait_done(10);
        step(2);
        check_val("sim_nwr", wa.size(), 3);
        check_val("sim_d1", data_at(1), 32'h0019);
        check_val("sim_d2", data_at(2), 32'h0000);
        check_val("sim_cnt", entry_count, 1);

        // Abort by reset mid-RUN
        clear_log();
        ctrl_in = 3'b101; rec_en = 1'b1;
        step(5);
        check_val("abort_busy_pre", busy, 1);
        rst = 1'b0; rec_en = 1'b0;
        step(1);
        check_val("abort_we", mem_we, 0);
        check_val("abort_busy", busy, 0);
        rst = 1'b1;
        step(5);
        check_val("abort_nwr", wa.size(), 1);
        check_val("abort_no_done", done_cnt, 0);
        rec_en = 1'b1;
        step(2);
        check_val("abort_restart", {mem_we, mem_addr, mem_din}, {1'b1, 5'd0, 16'h1234});
        rec_en = 1'b0;
        wait_done(10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
